// File: rtl/isa_pkg.sv
// Shared instruction-set constants and the raw-word packer used by the encoder
// and, later, by any disassembler/decoder that reads the same format.
package isa_pkg;

    localparam int OPCODE_W = 5;
    localparam int RAW_W    = 18;

    localparam logic [OPCODE_W-1:0] OP_MATMUL           = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_MAX              = 5'd7;
    localparam logic [OPCODE_W-1:0] OP_SUM              = 5'd8;
    localparam logic [OPCODE_W-1:0] OP_COPY             = 5'd13;
    localparam logic [OPCODE_W-1:0] OP_ZERO             = 5'd14;
    localparam logic [OPCODE_W-1:0] OP_LOAD             = 5'd15;
    localparam logic [OPCODE_W-1:0] OP_STORE            = 5'd16;
    localparam logic [OPCODE_W-1:0] OP_LOOP             = 5'd17;
    localparam logic [OPCODE_W-1:0] OP_START_LOOP       = 5'd18;
    localparam logic [OPCODE_W-1:0] OP_JUMP_OR_END_LOOP = 5'd19;
    localparam logic [OPCODE_W-1:0] OP_LAST_LEGAL       = 5'd19;

    typedef logic [0:RAW_W-1] raw_word_t;

    typedef struct packed {
        logic       flag;
        logic [2:0] f3;
        logic [1:0] f2a;
        logic [1:0] f2b;
        logic [1:0] f2c;
        logic       b14;
        logic       b15;
    } instr_fields_t;

    // Bit 0 is the opcode MSB; any field not used by an opcode stays zero.
    function automatic raw_word_t pack_instr(input logic [OPCODE_W-1:0] opcode,
                                             input instr_fields_t        fields);
        raw_word_t raw;
        raw      = '0;
        raw[0:4] = opcode;
        case (opcode)
            OP_MAX, OP_SUM: raw[5] = fields.flag;
            OP_COPY: begin
                raw[5:6] = fields.f2a;
                raw[7:8] = fields.f2b;
            end
            OP_ZERO: raw[5:6] = fields.f2a;
            OP_LOAD, OP_STORE: begin
                raw[5:7]   = fields.f3;
                raw[8:9]   = fields.f2a;
                raw[10:11] = fields.f2b;
                raw[12:13] = fields.f2c;
                raw[14]    = fields.b14;
                raw[15]    = fields.b15;
            end
            OP_LOOP, OP_START_LOOP, OP_JUMP_OR_END_LOOP: raw[5:7] = fields.f3;
            default: ;
        endcase
        return raw;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Registered-only FIFO of raw instruction words; a separate occupancy count
// disambiguates full from empty since the pointers wrap naturally.
module instr_fifo
    import isa_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  raw_word_t        in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output raw_word_t        out_data,
    output logic [CNT_W-1:0] count
);

    raw_word_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // Gate the read port so an empty FIFO never shows stale words.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Packs host instruction requests into raw words, screens illegal opcodes and
// loop-nesting violations, and queues legal words for the control unit.
module instruction_encoder
    import isa_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int MAX_LOOP_DEPTH = 8,
    parameter int ERR_CNT_W      = 8,
    localparam int LD_W          = $clog2(MAX_LOOP_DEPTH + 1),
    localparam int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_opcode,
    input  logic                 in_flag,
    input  logic [2:0]           in_f3,
    input  logic [1:0]           in_f2a,
    input  logic [1:0]           in_f2b,
    input  logic [1:0]           in_f2c,
    input  logic                 in_b14,
    input  logic                 in_b15,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:17]          raw_instruction,
    output logic [LD_W-1:0]      loop_depth,
    output logic                 err_illegal,
    output logic                 err_loop,
    output logic [ERR_CNT_W-1:0] err_count
);

    instr_fields_t    fields;
    raw_word_t        packed_word;
    raw_word_t        fifo_data;
    logic             fifo_ready;
    logic [CNT_W-1:0] fifo_count;
    logic             accept;
    logic             is_illegal;
    logic             is_open;
    logic             is_close;
    logic             loop_violation;
    logic             push;
    logic             drop;

    assign fields = '{flag: in_flag, f3: in_f3, f2a: in_f2a, f2b: in_f2b,
                      f2c: in_f2c, b14: in_b14, b15: in_b15};
    assign packed_word = pack_instr(in_opcode, fields);

    assign in_ready = fifo_ready && (fifo_count != CNT_W'(DEPTH));
    assign accept   = in_valid && in_ready;

    assign is_illegal = (in_opcode > OP_LAST_LEGAL);
    assign is_open    = (in_opcode == OP_LOOP) || (in_opcode == OP_START_LOOP);
    assign is_close   = (in_opcode == OP_JUMP_OR_END_LOOP);
    assign loop_violation = (is_open  && (loop_depth == LD_W'(MAX_LOOP_DEPTH))) ||
                            (is_close && (loop_depth == '0));

    assign push = accept && !is_illegal && !loop_violation;
    assign drop = accept && (is_illegal || loop_violation);

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (push),
        .in_ready  (fifo_ready),
        .in_data   (packed_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_data),
        .count     (fifo_count)
    );

    assign raw_instruction = fifo_data;

    // Depth tracks accepted loop words, not words leaving the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loop_depth  <= '0;
            err_illegal <= 1'b0;
            err_loop    <= 1'b0;
            err_count   <= '0;
        end else begin
            err_illegal <= accept && is_illegal;
            err_loop    <= accept && !is_illegal && loop_violation;
            if (push && is_open) begin
                loop_depth <= loop_depth + LD_W'(1);
            end else if (push && is_close) begin
                loop_depth <= loop_depth - LD_W'(1);
            end
            if (drop && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder with hand-computed raw words.
module tb_instruction_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic        in_flag;
    logic [2:0]  in_f3;
    logic [1:0]  in_f2a;
    logic [1:0]  in_f2b;
    logic [1:0]  in_f2c;
    logic        in_b14;
    logic        in_b15;
    logic        out_valid;
    logic        out_ready;
    logic [0:17] raw_instruction;
    logic [3:0]  loop_depth;
    logic        err_illegal;
    logic        err_loop;
    logic [7:0]  err_count;

    int tests_run;
    int tests_failed;

    instruction_encoder #(.DEPTH(4), .MAX_LOOP_DEPTH(8), .ERR_CNT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_opcode       (in_opcode),
        .in_flag         (in_flag),
        .in_f3           (in_f3),
        .in_f2a          (in_f2a),
        .in_f2b          (in_f2b),
        .in_f2c          (in_f2c),
        .in_b14          (in_b14),
        .in_b15          (in_b15),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .raw_instruction (raw_instruction),
        .loop_depth      (loop_depth),
        .err_illegal     (err_illegal),
        .err_loop        (err_loop),
        .err_count       (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [4:0] op, input logic flag, input logic [2:0] f3,
                           input logic [1:0] f2a, input logic [1:0] f2b, input logic [1:0] f2c,
                           input logic b14, input logic b15);
        in_opcode = op;
        in_flag   = flag;
        in_f3     = f3;
        in_f2a    = f2a;
        in_f2b    = f2b;
        in_f2c    = f2c;
        in_b14    = b14;
        in_b15    = b15;
        in_valid  = 1'b1;
    endtask

    // Presents one request for a single edge; caller ensures in_ready is high.
    task automatic send(input logic [4:0] op, input logic flag, input logic [2:0] f3,
                        input logic [1:0] f2a, input logic [1:0] f2b, input logic [1:0] f2c,
                        input logic b14, input logic b15);
        set_req(op, flag, f3, f2a, f2b, f2c, b14, b15);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [17:0] exp_words [5];
    logic [17:0] got_words [5];
    int          n_popped;
    logic        fifth_accepted;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        out_ready    = 1'b1;
        in_valid     = 1'b0;
        set_req(5'd0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_raw", raw_instruction, 0);
        check("reset_depth", loop_depth, 0);
        check("reset_err_count", err_count, 0);
        check("reset_err_pulses", {err_illegal, err_loop}, 0);
        reset = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 1);

        // COPY f2a=2 f2b=1
        send(5'd13, 1'b0, 3'd0, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0);
        check("copy_valid", out_valid, 1);
        check("copy_raw", raw_instruction, 32'h1B200);
        tick();
        check("copy_one_cycle", out_valid, 0);

        // LOAD then MAX back-to-back
        send(5'd15, 1'b0, 3'd5, 2'd3, 2'd0, 2'd2, 1'b1, 1'b0);
        check("load_raw", raw_instruction, 32'h1F728);
        send(5'd7, 1'b1, 3'd7, 2'd3, 2'd3, 2'd3, 1'b1, 1'b1);
        check("max_raw", raw_instruction, 32'h0F000);
        check("max_valid", out_valid, 1);
        tick();
        check("max_drained", out_valid, 0);

        // illegal opcode and loop underflow
        check("illegal_ready", in_ready, 1);
        send(5'd21, 1'b1, 3'd7, 2'd3, 2'd3, 2'd3, 1'b1, 1'b1);
        check("illegal_no_output", out_valid, 0);
        check("illegal_pulse", err_illegal, 1);
        check("illegal_count", err_count, 1);
        tick();
        check("illegal_pulse_end", err_illegal, 0);
        send(5'd19, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        check("underflow_pulse", err_loop, 1);
        check("underflow_count", err_count, 2);
        check("underflow_no_output", out_valid, 0);
        tick();
        check("underflow_pulse_end", err_loop, 0);

        // nest START_LOOP past the limit
        for (int i = 0; i < 9; i++) begin
            send(5'd18, 1'b0, 3'd3, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
            if (i < 8) begin
                check($sformatf("start_loop_raw_%0d", i), raw_instruction, 32'h24C00);
                check($sformatf("start_loop_depth_%0d", i), loop_depth, i + 1);
            end
        end
        check("overflow_pulse", err_loop, 1);
        check("overflow_depth", loop_depth, 8);
        check("overflow_no_output", out_valid, 0);
        check("overflow_count", err_count, 3);
        for (int i = 0; i < 8; i++) begin
            send(5'd19, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
            check($sformatf("end_loop_raw_%0d", i), raw_instruction, 32'h26000);
        end
        check("unwound_depth", loop_depth, 0);
        check("unwound_err_loop", err_loop, 0);
        tick();

        // backpressure: four fill the FIFO, fifth waits for the drain
        exp_words[0] = 18'h1B200;
        exp_words[1] = 18'h0F000;
        exp_words[2] = 18'h10000;
        exp_words[3] = 18'h1D800;
        exp_words[4] = 18'h12000;
        out_ready = 1'b0;
        send(5'd13, 1'b0, 3'd0, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0);
        send(5'd7,  1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        send(5'd8,  1'b0, 3'd7, 2'd3, 2'd3, 2'd3, 1'b1, 1'b1);
        check("bp_ready_before_4th", in_ready, 1);
        send(5'd14, 1'b1, 3'd7, 2'd3, 2'd2, 2'd1, 1'b1, 1'b1);
        check("bp_full_ready", in_ready, 0);
        check("bp_head_raw", raw_instruction, 32'h1B200);
        tick();
        check("bp_head_stable", raw_instruction, 32'h1B200);
        set_req(5'd9, 1'b1, 3'd7, 2'd3, 2'd3, 2'd3, 1'b1, 1'b1);
        out_ready      = 1'b1;
        check("bp_full_with_out_ready", in_ready, 0);
        n_popped       = 0;
        fifth_accepted = 1'b0;
        for (int cyc = 0; cyc < 20 && n_popped < 5; cyc++) begin
            if (out_valid && out_ready) begin
                got_words[n_popped] = raw_instruction;
                n_popped++;
            end
            if (in_valid && in_ready) fifth_accepted = 1'b1;
            tick();
            if (fifth_accepted) in_valid = 1'b0;
        end
        check("bp_fifth_accepted", fifth_accepted, 1);
        check("bp_pop_count", n_popped, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < n_popped) check($sformatf("bp_order_%0d", i), got_words[i], exp_words[i]);
        end
        check("bp_drained", out_valid, 0);

        // saturate the error counter
        for (int i = 0; i < 260; i++) begin
            send(5'd31, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        end
        check("err_count_saturated", err_count, 8'hFF);
        send(5'd20, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        check("err_count_no_wrap", err_count, 8'hFF);

        // reset with three queued loop words
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(5'd18, 1'b0, 3'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        end
        check("pre_reset_depth", loop_depth, 3);
        check("pre_reset_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_raw", raw_instruction, 0);
        check("async_reset_depth", loop_depth, 0);
        check("async_reset_err_count", err_count, 0);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            check("post_reset_no_glitch", {out_valid, raw_instruction}, 0);
        end
        check("post_reset_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
